mips_mainfsm: RTL and testbench

Multicycle MIPS main controller: a Moore-style state machine that sequences fetch, decode, execute, memory and writeback for each instruction. It generates every datapath enable and mux select, and produces the 2-bit `aluop` consumed by the ALU decoder alongside `funct`. It sits in the controller next to the ALU decoder and drives the shared-memory multicycle datapath, with a ready handshake on memory reads.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/mips_mainfsm_outdec.sv | 64 ++++++
 rtl/mips_mainfsm.sv | 55 +++++
 tb/tb_mips_mainfsm.sv | 119 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU operation codes, controller states and control word shared by the MIPS controller
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BEQ, ADDIEX, ORIEX, ITYPEWB, JUMP
  } state_t;
  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J};
  endfunction
endpackage

// File: rtl/mips_mainfsm_outdec.sv
// mainfsm_outdec: combinational map from controller state to datapath control word
module mainfsm_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   memready,
  output ctrl_t  ctrl
);
  // Moore decode; only the fetch write enables follow the memory handshake, undefined states drive all zeros
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = memready;
        ctrl.pcwrite = memready;
      end
      DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_OR;
      end
      ITYPEWB: ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_mainfsm.sv
// mips_mainfsm: multicycle MIPS main controller sequencing fetch, decode, execute, memory and writeback
module mips_mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);
  state_t state;
  ctrl_t  ctrl;
  // gating the handshake with reset_n keeps fetch writes off while reset is held
  mainfsm_outdec u_outdec (
    .state    (state),
    .memready (memready & reset_n),
    .ctrl     (ctrl)
  );
  assign {irwrite, pcwrite, branch, regwrite, memwrite, iord, alusrca, regdst,
          memtoreg, alusrcb, pcsrc, aluop} = ctrl;
  assign illegal = (state == DECODE) && !op_legal(op);
  // state register and next-state sequencing; op is read live from the IR, unknown encodings recover to FETCH
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else case (state)
      FETCH:   state <= memready ? DECODE : FETCH;
      DECODE: case (op)
        OP_LW, OP_SW: state <= MEMADR;
        OP_RTYPE:     state <= EXECUTE;
        OP_BEQ:       state <= BEQ;
        OP_ADDI:      state <= ADDIEX;
        OP_ORI:       state <= ORIEX;
        OP_J:         state <= JUMP;
        default:      state <= FETCH;
      endcase
      MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state <= memready ? MEMWB : MEMRD;
      EXECUTE: state <= ALUWB;
      ADDIEX,
      ORIEX:   state <= ITYPEWB;
      default: state <= FETCH;
    endcase
endmodule

// File: tb/tb_mips_mainfsm.sv
// tb_mips_mainfsm: randomized per-cycle check of the main controller against an instruction-level model
module tb_mips_mainfsm;
  import mips_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, memready = 1'b0;
  logic [5:0] op = '0;
  logic irwrite, pcwrite, branch, regwrite, memwrite, iord, alusrca, regdst, memtoreg, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [15:0] obs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mips_mainfsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .memready(memready),
    .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .alusrca(alusrca), .regdst(regdst),
    .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal(illegal)
  );
  assign obs = {irwrite, pcwrite, branch, regwrite, memwrite, iord, alusrca, regdst,
                memtoreg, alusrcb, pcsrc, aluop, illegal};
  function automatic logic [15:0] w(input logic irw, pcw, br, rw, mw, io, asa, rd, m2r,
                                    input logic [1:0] asb, pcs, aop, input logic ill);
    return {irw, pcw, br, rw, mw, io, asa, rd, m2r, asb, pcs, aop, ill};
  endfunction
  function automatic logic [15:0] fetch_w(input logic r);
    return w(r, r, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  // entered just after a rising edge with the controller expected in FETCH
  task automatic run_instr(input string tag, input logic [5:0] o, input int fw, input int mw);
    logic [15:0] q[$];
    logic r[$];
    logic legal;
    legal = o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J};
    for (int i = 0; i < fw; i++) begin q.push_back(fetch_w(0)); r.push_back(0); end
    q.push_back(fetch_w(1)); r.push_back(1);
    q.push_back(w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal)); r.push_back(rnd());
    if (o == OP_LW || o == OP_SW) begin
      q.push_back(w(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0)); r.push_back(rnd());
      if (o == OP_LW) begin
        for (int i = 0; i < mw; i++) begin
          q.push_back(w(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)); r.push_back(0);
        end
        q.push_back(w(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)); r.push_back(1);
        q.push_back(w(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0)); r.push_back(rnd());
      end else begin
        q.push_back(w(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)); r.push_back(rnd());
      end
    end else if (o == OP_RTYPE) begin
      q.push_back(w(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10, 0)); r.push_back(rnd());
      q.push_back(w(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0)); r.push_back(rnd());
    end else if (o == OP_ADDI || o == OP_ORI) begin
      q.push_back(w(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, (o == OP_ORI) ? 2'b11 : 2'b00, 0));
      r.push_back(rnd());
      q.push_back(w(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)); r.push_back(rnd());
    end else if (o == OP_BEQ) begin
      q.push_back(w(0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b01, 0)); r.push_back(rnd());
    end else if (o == OP_J) begin
      q.push_back(w(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0)); r.push_back(rnd());
    end
    for (int i = 0; i < q.size(); i++) begin
      memready = r[i];
      op = o;
      @(negedge clk);
      check($sformatf("%s op=%b cyc%0d", tag, o, i + 1), obs, q[i]);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [5:0] ops[8];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J, 6'b000000};
    memready = 1'b1;
    op = 6'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", obs, fetch_w(0));
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_instr("lw", OP_LW, 0, 0);
    run_instr("sw", OP_SW, 0, 0);
    run_instr("rtype", OP_RTYPE, 0, 0);
    run_instr("addi", OP_ADDI, 0, 0);
    run_instr("ori", OP_ORI, 0, 0);
    run_instr("beq", OP_BEQ, 0, 0);
    run_instr("j", OP_J, 0, 0);
    run_instr("lw_hs", OP_LW, 3, 2);
    run_instr("illegal", 6'b111111, 0, 0);
    memready = 1'b1;
    op = OP_LW;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid_memrd", obs, w(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    #2 reset_n = 1'b0;
    #1 check("rstmid_async", obs, fetch_w(0));
    @(posedge clk);
    #1 check("rstmid_hold", obs, fetch_w(0));
    reset_n = 1'b1;
    run_instr("post_rst", OP_RTYPE, 0, 0);
    repeat (150) begin
      logic [5:0] o;
      ops[7] = 6'($urandom);
      o = ops[$urandom_range(7, 0)];
      run_instr("rand", o, $urandom_range(2, 0), $urandom_range(2, 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
